// File: rtl/vga_pkg.sv
// Shared VGA timing constants, character motion defaults and types.
package vga_pkg;

    localparam int unsigned HOR_PIXELS       = 800;
    localparam int unsigned VER_PIXELS       = 600;

    localparam int unsigned CHAR_HGT_RST_DEF = 32;
    localparam int unsigned MOVE_STEP_DEF    = 4;
    localparam int unsigned JUMP_V0_DEF      = 12;
    localparam int unsigned GRAVITY_DEF      = 1;
    localparam int unsigned MAX_FALL_DEF     = 12;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } char_state_t;

    // Zero-extend a 12-bit coordinate into a 13-bit signed intermediate.
    function automatic logic signed [12:0] s13(input logic [11:0] v);
        return $signed({1'b0, v});
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bus; this slice carries only the vertical blank flag.
interface vga_if;
    logic vblnk;

    modport in  (input  vblnk);
    modport out (output vblnk);
endinterface

// File: rtl/frame_tick.sv
// One-cycle pulse on each rising edge of vblnk.
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick_c
);

    logic vblnk_q;

    // History register; reset high so a blank already in progress gives no tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b1;
        end else begin
            vblnk_q <= vblnk;
        end
    end

    assign tick_c = vblnk & ~vblnk_q;

endmodule

// File: rtl/char_ctrl.sv
// Character motion controller: per-frame walk, jump and gravity.
module char_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned SCREEN_W     = HOR_PIXELS,
    parameter int unsigned GROUND_Y     = VER_PIXELS - 20,
    parameter int unsigned CHAR_HGT_RST = CHAR_HGT_RST_DEF,
    parameter int unsigned MOVE_STEP    = MOVE_STEP_DEF,
    parameter int unsigned JUMP_V0      = JUMP_V0_DEF,
    parameter int unsigned GRAVITY      = GRAVITY_DEF,
    parameter int unsigned MAX_FALL     = MAX_FALL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        stepleft,
    input  logic        stepright,
    input  logic        jump,
    input  logic [11:0] char_hgt,
    input  logic [11:0] char_lng,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        on_ground
);

    localparam logic signed [12:0] GY13   = 13'(GROUND_Y);
    localparam logic signed [12:0] SWM1   = 13'(SCREEN_W - 1);
    localparam logic signed [12:0] STEP13 = 13'(MOVE_STEP);
    localparam logic [11:0]        X_RST  = 12'(SCREEN_W / 2);
    localparam logic [11:0]        Y_RST  = 12'(GROUND_Y - CHAR_HGT_RST);
    localparam logic [7:0]         V0     = 8'(JUMP_V0);
    localparam logic [7:0]         GRAV8  = 8'(GRAVITY);
    localparam logic [8:0]         GRAV9  = 9'(GRAVITY);
    localparam logic [8:0]         MAXF9  = 9'(MAX_FALL);
    localparam logic [7:0]         MAXF8  = 8'(MAX_FALL);

    logic              tick_c;
    char_state_t       state, state_nxt;
    logic [7:0]        vel, vel_nxt;
    logic [11:0]       pos_x_nxt, pos_y_nxt;
    logic              on_ground_nxt;

    logic signed [12:0] gc, x_lo, x_hi, x_try, y_up, y_dn, vel13;
    logic [8:0]         vel_inc;

    frame_tick u_frame_tick (
        .clk    (clk),
        .rst    (rst),
        .vblnk  (vga_in.vblnk),
        .tick_c (tick_c)
    );

    // State, velocity and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GROUND;
            vel       <= 8'd0;
            pos_x     <= X_RST;
            pos_y     <= Y_RST;
            on_ground <= 1'b1;
        end else begin
            state     <= state_nxt;
            vel       <= vel_nxt;
            pos_x     <= pos_x_nxt;
            pos_y     <= pos_y_nxt;
            on_ground <= on_ground_nxt;
        end
    end

    // Next-state logic: everything holds except in the tick cycle.
    always_comb begin
        state_nxt = state;
        vel_nxt   = vel;
        pos_x_nxt = pos_x;
        pos_y_nxt = pos_y;

        gc      = GY13 - s13(char_hgt);
        x_lo    = s13(char_lng);
        x_hi    = SWM1 - s13(char_lng);
        vel13   = s13({4'd0, vel});
        y_up    = s13(pos_y) - vel13;
        y_dn    = s13(pos_y) + vel13;
        vel_inc = {1'b0, vel} + GRAV9;

        x_try = s13(pos_x);
        if (stepleft && !stepright) begin
            x_try = s13(pos_x) - STEP13;
        end else if (stepright && !stepleft) begin
            x_try = s13(pos_x) + STEP13;
        end

        if (tick_c) begin
            if (x_try < x_lo) begin
                pos_x_nxt = char_lng;
            end else if (x_try > x_hi) begin
                pos_x_nxt = x_hi[11:0];
            end else begin
                pos_x_nxt = x_try[11:0];
            end

            unique case (state)
                GROUND: begin
                    if (jump) begin
                        state_nxt = RISE;
                        vel_nxt   = V0;
                    end else begin
                        pos_y_nxt = gc[11:0];
                    end
                end
                RISE: begin
                    if (y_up < s13(char_hgt)) begin
                        pos_y_nxt = char_hgt;
                        vel_nxt   = 8'd0;
                        state_nxt = FALL;
                    end else if (vel <= GRAV8) begin
                        pos_y_nxt = y_up[11:0];
                        vel_nxt   = 8'd0;
                        state_nxt = FALL;
                    end else begin
                        pos_y_nxt = y_up[11:0];
                        vel_nxt   = vel - GRAV8;
                    end
                end
                FALL: begin
                    if (y_dn >= gc) begin
                        pos_y_nxt = gc[11:0];
                        vel_nxt   = 8'd0;
                        state_nxt = GROUND;
                    end else begin
                        pos_y_nxt = y_dn[11:0];
                        vel_nxt   = (vel_inc > MAXF9) ? MAXF8 : vel_inc[7:0];
                    end
                end
                default: begin
                    state_nxt = GROUND;
                    vel_nxt   = 8'd0;
                end
            endcase
        end

        on_ground_nxt = (state_nxt == GROUND);
    end

endmodule

// File: tb/tb_char_ctrl.sv
// Directed bench for char_ctrl: walk/clamp vector table plus jump sequences.
module tb_char_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stepleft, stepright, jump;
    logic [11:0] char_hgt, char_lng;
    logic [11:0] pos_x, pos_y;
    logic        on_ground;

    int checks   = 0;
    int failures = 0;

    vga_if vif ();

    char_ctrl #(
        .SCREEN_W (800),
        .GROUND_Y (580)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_in    (vif),
        .stepleft  (stepleft),
        .stepright (stepright),
        .jump      (jump),
        .char_hgt  (char_hgt),
        .char_lng  (char_lng),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .on_ground (on_ground)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sl;
        logic        sr;
        logic        jp;
        logic [11:0] lng;
        int          n;
        int          vlen;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        eg;
    } vec_t;

    vec_t vecs[12];
    int   ys[26];

    task automatic chk(input string name, input logic [11:0] ex, input logic [11:0] ey,
                       input logic eg);
        checks++;
        if (pos_x !== ex || pos_y !== ey || on_ground !== eg) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d g=%0b expected x=%0d y=%0d g=%0b",
                     name, pos_x, pos_y, on_ground, ex, ey, eg);
        end
    endtask

    // One frame: buttons valid only in the tick cycle, then vblnk stays high vlen cycles.
    task automatic do_tick(input logic sl, input logic sr, input logic jp, input int vlen);
        stepleft  = sl;
        stepright = sr;
        jump      = jp;
        vif.vblnk = 1'b1;
        @(posedge clk); #1;
        stepleft  = 1'b0;
        stepright = 1'b0;
        jump      = 1'b0;
        for (int i = 1; i < vlen; i++) begin
            @(posedge clk); #1;
        end
        vif.vblnk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        stepleft  = 1'b0;
        stepright = 1'b0;
        jump      = 1'b0;
        char_hgt  = 12'd32;
        char_lng  = 12'd25;
        vif.vblnk = 1'b0;

        vecs[0]  = '{"walk_r1",     1'b0, 1'b1, 1'b0, 12'd25, 1,   2,  12'd404, 12'd548, 1'b1};
        vecs[1]  = '{"walk_r2",     1'b0, 1'b1, 1'b0, 12'd25, 1,   2,  12'd408, 12'd548, 1'b1};
        vecs[2]  = '{"walk_r3_long",1'b0, 1'b1, 1'b0, 12'd25, 1,   50, 12'd412, 12'd548, 1'b1};
        vecs[3]  = '{"both_1",      1'b1, 1'b1, 1'b0, 12'd25, 1,   2,  12'd412, 12'd548, 1'b1};
        vecs[4]  = '{"both_2",      1'b1, 1'b1, 1'b0, 12'd25, 1,   2,  12'd412, 12'd548, 1'b1};
        vecs[5]  = '{"none",        1'b0, 1'b0, 1'b0, 12'd25, 1,   2,  12'd412, 12'd548, 1'b1};
        vecs[6]  = '{"left_to_27",  1'b1, 1'b0, 1'b0, 12'd27, 100, 2,  12'd27,  12'd548, 1'b1};
        vecs[7]  = '{"clamp_l1",    1'b1, 1'b0, 1'b0, 12'd25, 1,   2,  12'd25,  12'd548, 1'b1};
        vecs[8]  = '{"clamp_l2",    1'b1, 1'b0, 1'b0, 12'd25, 1,   2,  12'd25,  12'd548, 1'b1};
        vecs[9]  = '{"clamp_r",     1'b0, 1'b1, 1'b0, 12'd25, 200, 2,  12'd774, 12'd548, 1'b1};
        vecs[10] = '{"clamp_r_hold",1'b0, 1'b1, 1'b0, 12'd25, 1,   2,  12'd774, 12'd548, 1'b1};
        vecs[11] = '{"off_right",   1'b1, 1'b0, 1'b0, 12'd25, 1,   2,  12'd770, 12'd548, 1'b1};

        ys = '{548, 536, 525, 515, 506, 498, 491, 485, 480, 476, 473, 471, 470,
               470, 471, 473, 476, 480, 485, 491, 498, 506, 515, 525, 536, 548};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then idle with no vblnk edges.
        chk("reset", 12'd400, 12'd548, 1'b1);
        repeat (20) @(posedge clk);
        #1 chk("idle", 12'd400, 12'd548, 1'b1);

        // Walking and clamping vectors.
        for (int v = 0; v < 12; v++) begin
            char_lng = vecs[v].lng;
            for (int k = 0; k < vecs[v].n; k++) begin
                do_tick(vecs[v].sl, vecs[v].sr, vecs[v].jp, vecs[v].vlen);
            end
            chk(vecs[v].name, vecs[v].ex, vecs[v].ey, vecs[v].eg);
        end

        // Single jump, with mid-air jump pulses that must be ignored.
        for (int i = 0; i < 26; i++) begin
            do_tick(1'b0, 1'b0, (i == 0) || (i == 5) || (i == 18), 2);
            chk($sformatf("jump_t%0d", i), 12'd770, 12'(ys[i]), i == 25);
        end

        // Held jump: identical arc, then relaunch on the tick after landing.
        for (int i = 0; i < 26; i++) begin
            do_tick(1'b0, 1'b0, 1'b1, 2);
        end
        chk("held_land", 12'd770, 12'd548, 1'b1);
        do_tick(1'b0, 1'b0, 1'b1, 2);
        chk("relaunch", 12'd770, 12'd548, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            do_tick(1'b0, 1'b0, 1'b1, 2);
        end
        chk("apex2", 12'd770, 12'd470, 1'b0);

        // Reset at apex with vblnk held high: no spurious tick afterwards.
        vif.vblnk = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst", 12'd400, 12'd548, 1'b1);
        rst       = 1'b0;
        stepright = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("no_tick_after_rst", 12'd400, 12'd548, 1'b1);
        stepright = 1'b0;
        vif.vblnk = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_ctrl.md
# char_ctrl

Character motion controller: the producer of the `pos_x`/`pos_y` centre coordinates that `char_draw` consumes. It reads the character half-extents back from `char_draw`, samples player buttons, and updates position once per video frame. The update tick comes from the rising edge of `vblnk`. Motion covers horizontal walking with screen-edge clamping and a jump/gravity state machine landing on a fixed ground line. The block sits beside `char_draw` on the same `vga_if` bus as a read-only tap.

## Interface
Parameters:
- `SCREEN_W`, default `HOR_PIXELS`: visible width in pixels.
- `GROUND_Y`, default `VER_PIXELS - 20`: y of the ground line (character bottom edge).
- `CHAR_HGT_RST`, default 32: half-height used for the reset position.
- `MOVE_STEP`, default 4: horizontal pixels per frame.
- `JUMP_V0`, default 12: initial upward velocity in pixels/frame.
- `GRAVITY`, default 1: velocity change per frame.
- `MAX_FALL`, default 12: downward velocity cap.

Ports:
- `clk` in 1: pixel clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `vga_in` `vga_if.in`: timing tap. Only `vblnk` is used.
- `stepleft` in 1: level, already synchronised.
- `stepright` in 1: level, already synchronised.
- `jump` in 1: level, already synchronised.
- `char_hgt` in 12: half-height from `char_draw`.
- `char_lng` in 12: half-width from `char_draw`.
- `pos_x` out 12: character centre x (registered).
- `pos_y` out 12: character centre y (registered).
- `on_ground` out 1: high in state GROUND (registered).

## Operation
- **Frame tick.** `tick` is high for exactly one cycle when `vblnk` is 1 this cycle and was 0 last cycle. A `vblnk` held high for many cycles produces one tick. All state updates happen only on `tick`.
- **Ground centre.** `gc = GROUND_Y - char_hgt`.
- **Horizontal motion** (every tick, any state):
  - `stepleft` xor `stepright` moves `pos_x` by ∓/±`MOVE_STEP`.
  - Both pressed, or neither: no move.
  - Result is clamped to `[char_lng, SCREEN_W-1-char_lng]`.
- **Vertical FSM** `{GROUND, RISE, FALL}`, with internal unsigned 8-bit `vel`:
  - GROUND:
    - `pos_y <= gc` (re-snaps if `char_hgt` changes).
    - `jump` → RISE, `vel <= JUMP_V0`, `pos_y` unchanged this tick.
  - RISE:
    - `pos_y <= pos_y - vel`.
    - If `vel <= GRAVITY` → FALL with `vel <= 0`; else `vel <= vel - GRAVITY`.
    - Ceiling: if `pos_y - vel < char_hgt`, then `pos_y <= char_hgt`, `vel <= 0`, FALL.
  - FALL:
    - `nxt = pos_y + vel`.
    - If `nxt >= gc`: `pos_y <= gc`, `vel <= 0`, GROUND.
    - Else: `pos_y <= nxt`, `vel <= min(vel + GRAVITY, MAX_FALL)`.
- `jump` is ignored in RISE and FALL. Holding `jump` relaunches on the first tick after landing.
- **Arithmetic.** All comparisons use 13-bit signed intermediates, so subtraction never wraps. Outputs are the low 12 bits of the clamped values.
- **Reset values:**
  - `pos_x = SCREEN_W/2`, `pos_y = GROUND_Y - CHAR_HGT_RST`, `on_ground = 1`.
  - State GROUND, `vel = 0`, `vblnk` history register = 1, so no spurious tick follows reset.
- **Reset mid-operation.** Any state returns to the reset values on the next edge.

## Timing
- Tick asserted in cycle N means the new `pos_x`, `pos_y`, `on_ground` are visible from cycle N+1.
- The tick falls at the start of vertical blank, so `char_draw` latches the new position before the next active frame.
- Outputs hold their value for the whole frame between ticks.
- Buttons and `char_hgt`/`char_lng` are sampled only in the tick cycle.

## Structure
- `char_state_t` enum (GROUND/RISE/FALL) goes in `vga_pkg`. The motion default constants go there too, next to `HOR_PIXELS`/`VER_PIXELS`.
- One sub-module: `frame_tick`, a `vblnk` rising-edge detector with synchronous reset. It is reusable by later per-frame blocks.

## Test plan
Bench parameters: `SCREEN_W=800`, `GROUND_Y=580`, `char_hgt=32`, `char_lng=25`, defaults otherwise.
- **Reset and idle.** Reset, then no `vblnk` edges → `pos_x=400`, `pos_y=548`, `on_ground=1`, constant.
- **Walk right / both buttons.** `stepright` held 3 ticks → `pos_x=412`. Then both buttons held 2 ticks → stays 412. A 50-cycle `vblnk` pulse counts as one tick.
- **Edge clamps.** From `pos_x=27`, `stepleft` 2 ticks → 25, 25. Sustained `stepright` saturates at 774.
- **Single jump.** One-tick `jump` pulse:
  - `pos_y` sequence 548, 536, 525, … reaches apex 470 (12+11+…+1 = 78) and `on_ground=0`.
  - Then falls and lands exactly at 548 with `on_ground=1`.
  - `jump` pulsed mid-air has no effect.
- **Held jump / mid-jump reset.** `jump` held → relaunch on the tick after landing. `rst` asserted at apex → next cycle `pos_x=400`, `pos_y=548`, `on_ground=1`.
